i2s_rx: RTL and testbench

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_rx.sv | 179 +++++++++++++++++
 tb/tb_i2s_rx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sck/ws/sd on i_clk, frames left/right words and presents
// them as a held stereo pair with valid/ready handshake, plus overflow and framing-error pulses.
module i2s_rx #(
  parameter int DW      = 32,
  parameter int MIN_OSR = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_enable,
  input  logic          i_sck,
  input  logic          i_ws,
  input  logic          i_sd,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data_left,
  output logic [DW-1:0] o_data_right,
  output logic          o_ovf,
  output logic          o_err,
  output logic          o_locked
);

  localparam int CW = $clog2(DW + 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LEFT  = 2'd1;
  localparam logic [1:0] S_RIGHT = 2'd2;

  if (DW < 8 || DW > 32 || MIN_OSR < 2) begin : g_param_check
    $error("i2s_rx: DW must be 8..32 and MIN_OSR at least 2");
  end

  logic          sck_s1_q, sck_s1_d, sck_s2_q, sck_s2_d;
  logic          ws_s1_q, ws_s1_d, ws_s2_q, ws_s2_d;
  logic          sd_s1_q, sd_s1_d, sd_s2_q, sd_s2_d;
  logic          sck_prev_q, sck_prev_d;
  logic          ws_prev_q, ws_prev_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [1:0]    state_q, state_d;
  logic [DW-1:0] left_hold_q, left_hold_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] data_l_q, data_l_d;
  logic [DW-1:0] data_r_q, data_r_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;

  logic rise, trans, cnt_full, pair_done;

  always_comb begin
    sck_s1_d    = i_sck;
    sck_s2_d    = sck_s1_q;
    ws_s1_d     = i_ws;
    ws_s2_d     = ws_s1_q;
    sd_s1_d     = i_sd;
    sd_s2_d     = sd_s1_q;
    sck_prev_d  = sck_s2_q;
    ws_prev_d   = ws_prev_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    state_d     = state_q;
    left_hold_d = left_hold_q;
    valid_d     = valid_q;
    data_l_d    = data_l_q;
    data_r_d    = data_r_q;
    ovf_d       = 1'b0;
    err_d       = 1'b0;
    pair_done   = 1'b0;

    rise     = sck_s2_q & ~sck_prev_q;
    trans    = rise & (ws_s2_q != ws_prev_q);
    cnt_full = (bit_cnt_q == CW'(DW));

    // ws history is tracked even while disabled so re-enable sees real transitions
    if (rise) ws_prev_d = ws_s2_q;

    if (!i_enable) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      shreg_d   = '0;
      valid_d   = 1'b0;
    end else begin
      if (rise) begin
        if (trans) begin
          shreg_d   = {{(DW-1){1'b0}}, sd_s2_q};
          bit_cnt_d = CW'(1);
        end else begin
          shreg_d = {shreg_q[DW-2:0], sd_s2_q};
          if (bit_cnt_q != CW'(DW + 1)) bit_cnt_d = bit_cnt_q + CW'(1);
        end

        // shreg_q still holds the word that just finished when trans is seen
        if (trans) begin
          case (state_q)
            S_IDLE: if (!ws_s2_q) state_d = S_LEFT;
            S_LEFT: begin
              if (ws_s2_q) begin
                if (cnt_full) begin
                  left_hold_d = shreg_q;
                  state_d     = S_RIGHT;
                end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
                end
              end
            end
            S_RIGHT: begin
              if (!ws_s2_q) begin
                state_d = S_LEFT;
                if (cnt_full) pair_done = 1'b1;
                else          err_d     = 1'b1;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      if (pair_done) begin
        if (!valid_q || i_ready) begin
          data_l_d = left_hold_q;
          data_r_d = shreg_q;
          valid_d  = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (valid_q && i_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sck_s1_q    <= 1'b0;
      sck_s2_q    <= 1'b0;
      ws_s1_q     <= 1'b0;
      ws_s2_q     <= 1'b0;
      sd_s1_q     <= 1'b0;
      sd_s2_q     <= 1'b0;
      sck_prev_q  <= 1'b0;
      ws_prev_q   <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      state_q     <= S_IDLE;
      left_hold_q <= '0;
      valid_q     <= 1'b0;
      data_l_q    <= '0;
      data_r_q    <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sck_s1_q    <= sck_s1_d;
      sck_s2_q    <= sck_s2_d;
      ws_s1_q     <= ws_s1_d;
      ws_s2_q     <= ws_s2_d;
      sd_s1_q     <= sd_s1_d;
      sd_s2_q     <= sd_s2_d;
      sck_prev_q  <= sck_prev_d;
      ws_prev_q   <= ws_prev_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      state_q     <= state_d;
      left_hold_q <= left_hold_d;
      valid_q     <= valid_d;
      data_l_q    <= data_l_d;
      data_r_q    <= data_r_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_data_left  = data_l_q;
  assign o_data_right = data_r_q;
  assign o_ovf        = ovf_q;
  assign o_err        = err_q;
  assign o_locked     = (state_q == S_LEFT) || (state_q == S_RIGHT);

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: an I2S transmitter model at i_clk = 8x sck, a frame table, and a
// scoreboard comparing expected stereo pairs against pairs the DUT hands over.
module tb_i2s_rx;
  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst, i_enable, i_sck, i_ws, i_sd, i_ready;
  logic          o_valid, o_ovf, o_err, o_locked;
  logic [DW-1:0] o_data_left, o_data_right;

  i2s_rx #(.DW(DW), .MIN_OSR(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_sck(i_sck), .i_ws(i_ws),
    .i_sd(i_sd), .i_ready(i_ready), .o_valid(o_valid), .o_data_left(o_data_left),
    .o_data_right(o_data_right), .o_ovf(o_ovf), .o_err(o_err), .o_locked(o_locked)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [DW-1:0] l; logic [DW-1:0] r; int lbits; bit exp_pair; } frame_t;
  typedef struct { logic [DW-1:0] l; logic [DW-1:0] r; } pair_t;

  frame_t frames[8];
  pair_t  exp_q[$];
  pair_t  got_q[$];
  int     checks = 0;
  int     errors = 0;
  int     err_cnt = 0, err_hi = 0, ovf_cnt = 0, ovf_hi = 0;
  bit     unstable = 1'b0;

  logic          valid_p = 1'b0, acc_p = 1'b0, err_p = 1'b0, ovf_p = 1'b0;
  logic [DW-1:0] l_p = '0, r_p = '0;

  // Output monitor: records every accepted pair, pulse edges/widths, and data stability
  always @(negedge i_clk) begin
    if (i_rst) begin
      valid_p <= 1'b0;
      acc_p   <= 1'b0;
      err_p   <= 1'b0;
      ovf_p   <= 1'b0;
    end else begin
      if (o_valid && valid_p && !acc_p && (o_data_left !== l_p || o_data_right !== r_p))
        unstable <= 1'b1;
      if (o_valid && i_ready) got_q.push_back('{l: o_data_left, r: o_data_right});
      if (o_err) err_hi <= err_hi + 1;
      if (o_err && !err_p) err_cnt <= err_cnt + 1;
      if (o_ovf) ovf_hi <= ovf_hi + 1;
      if (o_ovf && !ovf_p) ovf_cnt <= ovf_cnt + 1;
      valid_p <= o_valid;
      acc_p   <= o_valid && i_ready;
      l_p     <= o_data_left;
      r_p     <= o_data_right;
      err_p   <= o_err;
      ovf_p   <= o_ovf;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  // Data and ws change while sck is low; the receiver samples on the sck rise.
  task automatic send_bit(input logic ws, input logic sd);
    i_ws = ws;
    i_sd = sd;
    #40 i_sck = 1'b1;
    #40 i_sck = 1'b0;
  endtask

  task automatic send_half(input logic ws, input logic [DW-1:0] d, input int n);
    for (int i = 0; i < n; i++) send_bit(ws, d[DW-1-i]);
  endtask

  task automatic send_frame(input int idx, input bit push);
    if (push && frames[idx].exp_pair) exp_q.push_back('{l: frames[idx].l, r: frames[idx].r});
    send_half(1'b0, frames[idx].l, frames[idx].lbits);
    send_half(1'b1, frames[idx].r, DW);
  endtask

  task automatic flush();
    send_bit(1'b0, 1'b0);
    settle(4);
  endtask

  task automatic resync();
    i_enable = 1'b0;
    send_bit(1'b1, 1'b0);
    i_enable = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
  endtask

  task automatic check_sb(input string name);
    pair_t e, g;
    settle(4);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({name, "_left"}, g.l, e.l);
      chk({name, "_right"}, g.r, e.r);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  int e0, o0;

  initial begin
    frames[0] = '{32'hA5A5_0F0F, 32'h1234_5678, 32, 1'b1};
    frames[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 32, 1'b1};
    frames[2] = '{32'h8000_0000, 32'h7FFF_FFFF, 32, 1'b1};
    frames[3] = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 31, 1'b0};
    frames[4] = '{32'h0123_4567, 32'h89AB_CDEF, 32, 1'b1};
    frames[5] = '{32'h5555_AAAA, 32'h3C3C_C3C3, 32, 1'b1};
    frames[6] = '{32'h0F1E_2D3C, 32'hF0E1_D2C3, 32, 1'b1};
    frames[7] = '{32'h1111_2222, 32'h3333_4444, 32, 1'b1};

    i_rst = 1'b1; i_enable = 1'b0; i_sck = 1'b0; i_ws = 1'b0; i_sd = 1'b0; i_ready = 1'b0;
    settle(3);
    chk("rst_valid", o_valid, 0);
    chk("rst_left", o_data_left, 0);
    chk("rst_right", o_data_right, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_err", o_err, 0);
    chk("rst_locked", o_locked, 0);
    i_rst = 1'b0;
    settle(2);

    // Continuous reception with the consumer always ready
    i_ready = 1'b1;
    e0 = err_cnt; o0 = ovf_cnt;
    resync();
    for (int i = 0; i < 3; i++) send_frame(0, 1'b1);
    for (int i = 1; i < 3; i++) send_frame(i, 1'b1);
    flush();
    check_sb("stream");
    chk("stream_err", err_cnt - e0, 0);
    chk("stream_ovf", ovf_cnt - o0, 0);
    chk("stream_locked", o_locked, 1);
    chk("stream_valid_idle", o_valid, 0);

    // Short left channel, then a good frame
    resync();
    e0 = err_cnt;
    send_half(1'b0, frames[3].l, frames[3].lbits);
    send_bit(1'b1, frames[3].r[DW-1]);
    settle(1);
    chk("short_locked", o_locked, 0);
    chk("short_err", err_cnt - e0, 1);
    send_half(1'b1, frames[3].r, DW - 1);
    send_frame(4, 1'b1);
    flush();
    check_sb("short");
    chk("short_relocked", o_locked, 1);

    // Consumer stalled across three frames
    i_ready = 1'b0;
    resync();
    o0 = ovf_cnt;
    send_frame(5, 1'b1);
    send_frame(6, 1'b0);
    send_frame(7, 1'b0);
    flush();
    chk("stall_valid", o_valid, 1);
    chk("stall_left", o_data_left, frames[5].l);
    chk("stall_right", o_data_right, frames[5].r);
    chk("stall_ovf", ovf_cnt - o0, 2);
    i_ready = 1'b1;
    settle(3);
    chk("stall_cleared", o_valid, 0);
    check_sb("stall");

    // Accept coincides with the pair-complete cycle
    i_ready = 1'b0;
    resync();
    o0 = ovf_cnt;
    send_frame(0, 1'b1);
    send_frame(1, 1'b1);
    i_ws = 1'b0; i_sd = 1'b0;
    #40 i_sck = 1'b1;
    @(posedge i_clk);
    @(posedge i_clk);
    #1 i_ready = 1'b1;
    @(posedge i_clk);
    #1 i_ready = 1'b0;
    #20 i_sck = 1'b0;
    #40;
    settle(2);
    chk("same_valid", o_valid, 1);
    chk("same_left", o_data_left, frames[1].l);
    chk("same_right", o_data_right, frames[1].r);
    chk("same_ovf", ovf_cnt - o0, 0);
    i_ready = 1'b1;
    settle(3);
    chk("same_cleared", o_valid, 0);
    check_sb("same");

    // Enable in the middle of a right channel
    e0 = err_cnt;
    i_enable = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_half(1'b0, frames[6].l, DW);
    send_half(1'b1, frames[6].r, 16);
    i_enable = 1'b1;
    send_half(1'b1, frames[6].r, 16);
    chk("midright_locked", o_locked, 0);
    exp_q.push_back('{l: frames[7].l, r: frames[7].r});
    send_half(1'b0, frames[7].l, 1);
    settle(1);
    chk("midright_relock", o_locked, 1);
    send_half(1'b0, frames[7].l << 1, DW - 1);
    send_half(1'b1, frames[7].r, DW);
    flush();
    check_sb("midright");
    chk("midright_err", err_cnt - e0, 0);

    // Reset mid-left with a pair pending
    i_ready = 1'b0;
    resync();
    send_frame(4, 1'b0);
    send_half(1'b0, frames[5].l, 5);
    chk("rst2_pending", o_valid, 1);
    i_rst = 1'b1;
    #1;
    chk("rst2_valid", o_valid, 0);
    chk("rst2_left", o_data_left, 0);
    chk("rst2_right", o_data_right, 0);
    chk("rst2_locked", o_locked, 0);
    chk("rst2_err", o_err, 0);
    chk("rst2_ovf", o_ovf, 0);
    #20 i_rst = 1'b0;
    send_half(1'b0, frames[5].l << 5, DW - 5);
    send_half(1'b1, frames[5].r, DW);
    chk("rst2_unlocked", o_locked, 0);
    send_frame(5, 1'b1);
    flush();
    i_ready = 1'b1;
    check_sb("rst2");

    // Enable dropped mid-frame with a pair pending
    i_ready = 1'b0;
    resync();
    send_frame(6, 1'b0);
    send_half(1'b0, frames[7].l, 4);
    chk("dis_pending", o_valid, 1);
    i_enable = 1'b0;
    settle(1);
    chk("dis_valid", o_valid, 0);
    chk("dis_locked", o_locked, 0);
    i_enable = 1'b1;
    send_half(1'b0, frames[7].l << 4, DW - 4);
    chk("dis_wait", o_locked, 0);
    send_half(1'b1, frames[7].r, DW);
    send_frame(7, 1'b1);
    flush();
    i_ready = 1'b1;
    check_sb("dis");

    chk("total_err", err_cnt, 1);
    chk("total_ovf", ovf_cnt, 2);
    chk("err_width", err_hi, err_cnt);
    chk("ovf_width", ovf_hi, ovf_cnt);
    chk("data_stable", unstable, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
